// File: rtl/dma_uart_pkg.sv
// Shared definitions for the DMA UART link: frame layout, cherry word geometry
// and the frame-assembly state encoding used by both the TX and RX sides.
package dma_uart_pkg;

    localparam int FRAME_BYTES    = 3;
    localparam int UART_DATA_BITS = 8;
    localparam int CMD_WE_BIT     = 7;
    localparam int DAT_HI_LSB     = 10;
    localparam int DAT_LO_LSB     = 2;
    localparam int CHERRY_W       = 18;
    localparam int ADDR_W         = 7;

    typedef enum logic [1:0] {
        FRAME_CMD = 2'd0,
        FRAME_HI  = 2'd1,
        FRAME_LO  = 2'd2
    } frame_state_e;

    // Rebuild an 18-bit cherry word from its two transported bytes; the two
    // LSBs dropped by the transmitter come back as zeros.
    function automatic logic [CHERRY_W-1:0] widenCherry(input logic [7:0] hi,
                                                        input logic [7:0] lo);
        logic [CHERRY_W-1:0] word;
        word                          = '0;
        word[DAT_HI_LSB +: 8]         = hi;
        word[DAT_LO_LSB +: 8]         = lo;
        return word;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-byte UART receiver: 2-flop synchroniser on the pin, then an 8N1
// deserialiser that samples each bit mid-period, LSB first.
module uart_rx_byte
    import dma_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byteValid,
    output logic       o_byteErr,
    output logic       o_rxIdle
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rxdS;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_clkCnt;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_shift;
    logic             r_errWait;
    logic             r_byteValid;
    logic             r_byteErr;

    // Presetting to 1 keeps a reset release from looking like a start bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxdS = r_sync2;

    // After a bad stop bit the FSM parks in STOP until the line goes high,
    // so a held-low (break) line cannot retrigger a stream of bogus bytes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_clkCnt    <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_errWait   <= 1'b0;
            r_byteValid <= 1'b0;
            r_byteErr   <= 1'b0;
        end else begin
            r_byteValid <= 1'b0;
            r_byteErr   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clkCnt  <= '0;
                    r_bitCnt  <= '0;
                    r_errWait <= 1'b0;
                    if (!w_rxdS) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_clkCnt == HALF_LAST) begin
                        r_clkCnt <= '0;
                        r_state  <= w_rxdS ? ST_IDLE : ST_DATA;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_clkCnt == FULL_LAST) begin
                        r_clkCnt <= '0;
                        r_shift  <= {w_rxdS, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 1'b1;
                        if (r_bitCnt == LAST_BIT) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_errWait) begin
                        if (w_rxdS) begin
                            r_errWait <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end else if (r_clkCnt == FULL_LAST) begin
                        r_clkCnt <= '0;
                        if (w_rxdS) begin
                            r_byteValid <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_byteErr <= 1'b1;
                            r_errWait <= 1'b1;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_byte      = r_shift;
    assign o_byteValid = r_byteValid;
    assign o_byteErr   = r_byteErr;
    assign o_rxIdle    = (r_state == ST_IDLE);

endmodule

// File: rtl/dma_uart_rx.sv
// Receive side of the DMA UART link: assembles 3-byte host frames into
// {we, addr, cherry word} DMA writes, with framing-error and inter-byte timeout.
module dma_uart_rx
    import dma_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int TIMEOUT_CLKS = 208320
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rxd,
    output logic [CHERRY_W-1:0] dma_dat_r,
    output logic [ADDR_W-1:0]   dma_dat_addr,
    output logic                we,
    output logic                valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int              TO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CLKS);

    logic [7:0]          w_byte;
    logic                w_byteValid;
    logic                w_byteErr;
    logic                w_rxIdle;
    logic                w_counting;
    logic                w_timeout;

    frame_state_e        r_state;
    logic [7:0]          r_cmd;
    logic [7:0]          r_hi;
    logic [TO_W-1:0]     r_toCnt;
    logic [CHERRY_W-1:0] r_dat;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                r_valid;
    logic                r_frameErr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rxd       (uart_rxd),
        .o_byte      (w_byte),
        .o_byteValid (w_byteValid),
        .o_byteErr   (w_byteErr),
        .o_rxIdle    (w_rxIdle)
    );

    // Only line-idle time inside a frame counts toward the timeout.
    assign w_counting = (r_state != FRAME_CMD) && w_rxIdle;
    assign w_timeout  = w_counting && (r_toCnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_toCnt <= '0;
        end else if (w_byteValid) begin
            r_toCnt <= '0;
        end else if (w_counting && (r_toCnt != TO_MAX)) begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end

    // A byte error outranks everything; a timeout only acts when no byte
    // completes, so valid and frame_err can never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FRAME_CMD;
            r_cmd      <= '0;
            r_hi       <= '0;
            r_dat      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
            if (w_byteErr) begin
                r_state    <= FRAME_CMD;
                r_frameErr <= 1'b1;
            end else if (w_byteValid) begin
                case (r_state)
                    FRAME_CMD: begin
                        r_cmd   <= w_byte;
                        r_state <= FRAME_HI;
                    end
                    FRAME_HI: begin
                        r_hi    <= w_byte;
                        r_state <= FRAME_LO;
                    end
                    FRAME_LO: begin
                        r_dat   <= widenCherry(r_hi, w_byte);
                        r_addr  <= r_cmd[ADDR_W-1:0];
                        r_we    <= r_cmd[CMD_WE_BIT];
                        r_valid <= 1'b1;
                        r_state <= FRAME_CMD;
                    end
                    default: r_state <= FRAME_CMD;
                endcase
            end else if (w_timeout) begin
                r_state    <= FRAME_CMD;
                r_frameErr <= 1'b1;
            end
        end
    end

    assign dma_dat_r    = r_dat;
    assign dma_dat_addr = r_addr;
    assign we           = r_we;
    assign valid        = r_valid;
    assign frame_err    = r_frameErr;
    assign busy         = (r_state != FRAME_CMD) || !w_rxIdle;

endmodule

// File: tb/tb_dma_uart_rx.sv
// Scoreboard bench for dma_uart_rx: frames are serialised onto uart_rxd and
// the expected DMA writes are queued, then popped as valid pulses appear.
module tb_dma_uart_rx;

    localparam int CPB = 16;
    localparam int TO  = 320;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rxd;
    logic [17:0] dma_dat_r;
    logic [6:0]  dma_dat_addr;
    logic        we;
    logic        valid;
    logic        frame_err;
    logic        busy;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [17:0] dat;
    } exp_t;

    exp_t expQ[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   validCount = 0;
    int   errCount   = 0;
    int   lastErrCyc = -1;
    int   busyWatch  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dma_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .dma_dat_r    (dma_dat_r),
        .dma_dat_addr (dma_dat_addr),
        .we           (we),
        .valid        (valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    // Output monitor: pops the scoreboard on every valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid && frame_err) begin
                checks++;
                errors++;
                $display("[TB] FAIL valid_err_overlap got valid=1 frame_err=1 expected never both");
            end
            if (busyWatch > 0) begin
                busyWatch--;
                if (busyWatch == 0) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL busy_after_valid got %b expected 0", busy);
                    end
                end
            end
            if (valid) begin
                validCount++;
                busyWatch = 2;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_valid got addr=%h dat=%h expected no frame", dma_dat_addr, dma_dat_r);
                end else begin
                    e = expQ.pop_front();
                    if (we !== e.we || dma_dat_addr !== e.addr || dma_dat_r !== e.dat) begin
                        errors++;
                        $display("[TB] FAIL frame_data got we=%b addr=%h dat=%h expected we=%b addr=%h dat=%h",
                                 we, dma_dat_addr, dma_dat_r, e.we, e.addr, e.dat);
                    end
                end
            end
            if (frame_err) begin
                errCount++;
                lastErrCyc = cyc;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called and returning at a negedge; back-to-back calls leave no gap.
    task automatic sendByte(input logic [7:0] b, input logic stopBit, output int startCyc);
        startCyc = cyc;
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stopBit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input int gap);
        int s;
        exp_t e;
        e.we   = c[7];
        e.addr = c[6:0];
        e.dat  = {h, l, 2'b00};
        expQ.push_back(e);
        sendByte(c, 1'b1, s);
        repeat (gap) @(negedge clk);
        sendByte(h, 1'b1, s);
        repeat (gap) @(negedge clk);
        sendByte(l, 1'b1, s);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain got %0d pending expected 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        int busySeen = 0;
        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busySeen++;
        end
        checkCount("reset_valid_count", validCount, 0);
        checkCount("reset_err_count", errCount, 0);
        checkCount("reset_busy_cycles", busySeen, 0);
        checks++;
        if (dma_dat_r !== 18'h0 || dma_dat_addr !== 7'h0 || we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got we=%b addr=%h dat=%h expected 0 0 0", we, dma_dat_addr, dma_dat_r);
        end
    endtask

    task automatic test_back_to_back;
        int v0 = validCount;
        int e0 = errCount;
        sendFrame(8'h99, 8'hD7, 8'h45, 0);
        waitDrain("b2b");
        repeat (20) @(negedge clk);
        checkCount("b2b_valid_count", validCount, v0 + 1);
        checkCount("b2b_err_count", errCount, e0);
        checks++;
        if (dma_dat_r !== 18'h35D14 || dma_dat_addr !== 7'h19 || we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_hold got we=%b addr=%h dat=%h expected 1 19 35d14", we, dma_dat_addr, dma_dat_r);
        end
    endtask

    task automatic test_gaps;
        int v0 = validCount;
        sendFrame(8'h05, 8'hFF, 8'h01, 100);
        waitDrain("gaps");
        repeat (10) @(negedge clk);
        checkCount("gaps_valid_count", validCount, v0 + 1);
    endtask

    task automatic test_frame_err;
        int s;
        int v0 = validCount;
        int e0 = errCount;
        sendByte(8'h99, 1'b1, s);
        sendByte(8'hD7, 1'b0, s);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        checkCount("stop_err_count", errCount, e0 + 1);
        checkCount("stop_err_no_valid", validCount, v0);
        sendFrame(8'h80, 8'h00, 8'h00, 0);
        waitDrain("after_err");
        repeat (10) @(negedge clk);
        checkCount("after_err_valid_count", validCount, v0 + 1);
    endtask

    task automatic test_timeout;
        int s;
        int v0 = validCount;
        int e0 = errCount;
        sendByte(8'h99, 1'b1, s);
        repeat (400) @(negedge clk);
        checkCount("timeout_err_count", errCount, e0 + 1);
        // byte_valid lands 155 edges after the first edge sampling the start
        // bit; the timeout fires TO edges later and shows after that edge.
        checkCount("timeout_err_cycle", lastErrCyc, s + 1 + 155 + TO);
        checkCount("timeout_busy", int'(busy), 0);
        checkCount("timeout_no_valid", validCount, v0);
        sendFrame(8'h93, 8'hAB, 8'hCD, 0);
        waitDrain("after_timeout");
        repeat (10) @(negedge clk);
        checkCount("after_timeout_valid_count", validCount, v0 + 1);
    endtask

    task automatic test_glitch;
        int v0 = validCount;
        int e0 = errCount;
        int busySeen = 0;
        uart_rxd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busySeen = 1;
        end
        uart_rxd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busySeen = 1;
        end
        checkCount("glitch_busy_seen", busySeen, 1);
        checkCount("glitch_busy_final", int'(busy), 0);
        checkCount("glitch_valid_count", validCount, v0);
        checkCount("glitch_err_count", errCount, e0);
    endtask

    task automatic test_reset_mid_frame;
        int s;
        int v0 = validCount;
        int e0;
        sendByte(8'h11, 1'b1, s);
        sendByte(8'h22, 1'b1, s);
        uart_rxd = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dma_dat_r !== 18'h0 || dma_dat_addr !== 7'h0 || we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got we=%b addr=%h dat=%h busy=%b expected all 0",
                     we, dma_dat_addr, dma_dat_r, busy);
        end
        e0    = errCount;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkCount("midreset_err_count", errCount, e0);
        checkCount("midreset_busy", int'(busy), 0);
        sendFrame(8'h2A, 8'h12, 8'h34, 0);
        waitDrain("midreset");
        repeat (10) @(negedge clk);
        checkCount("midreset_valid_count", validCount, v0 + 1);
    endtask

    initial begin
        $display("[TB] dma_uart_rx bench start");
        test_reset();
        test_back_to_back();
        test_gaps();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
